// File: rtl/mux_nway_reg.sv
// Registered N-way multiplexer with valid/ready handshakes on every channel and on the output.
// The winning channel comes either from an external select or from a round-robin pointer.
module mux_nway_reg #(
    parameter int WIDTH = 32,
    parameter int WAYS  = 4,
    parameter int MODE  = 0,
    parameter int SELW  = $clog2(WAYS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WAYS*WIDTH-1:0]   in_data,
    input  logic [WAYS-1:0]         in_valid,
    output logic [WAYS-1:0]         in_ready,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SELW-1:0]         out_src
);

    logic               out_valid_reg;
    logic [WIDTH-1:0]   out_data_reg;
    logic [SELW-1:0]    out_src_reg;

    logic               can_load;
    logic               grant_valid;
    logic [SELW-1:0]    grant_idx;
    logic               load;
    logic [WIDTH-1:0]   grant_word;

    assign can_load = !out_valid_reg || out_ready;
    // Reset gating keeps in_ready low while reset_n is asserted, even if a word is still held.
    assign load     = reset_n && can_load && grant_valid;

    generate
        if (MODE == 0) begin : g_ext
            // An out-of-range sel matches no channel, so nothing is granted.
            always_comb begin
                grant_valid = 1'b0;
                grant_idx   = '0;
                for (int i = 0; i < WAYS; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SELW'(i);
                    end
                end
            end
        end else begin : g_rr
            logic [SELW-1:0] ptr_reg;
            logic [SELW-1:0] ptr_next;

            // Scan from the farthest position back to ptr so the last hit is the first in order.
            always_comb begin
                grant_valid = 1'b0;
                grant_idx   = '0;
                for (int k = WAYS - 1; k >= 0; k--) begin
                    int idx;
                    idx = int'(ptr_reg) + k;
                    if (idx >= WAYS) begin
                        idx = idx - WAYS;
                    end
                    if (in_valid[idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SELW'(idx);
                    end
                end
            end

            assign ptr_next = (grant_idx == SELW'(WAYS - 1)) ? '0 : grant_idx + SELW'(1);

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    ptr_reg <= '0;
                end else if (load) begin
                    ptr_reg <= ptr_next;
                end
            end
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_ready
            assign in_ready[gi] = load && (grant_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A load takes priority over a drain, which gives back-to-back transfers at full rate.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= grant_word;
            out_src_reg   <= grant_idx;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_mux_nway_reg.sv
// Directed bench for mux_nway_reg: external select (4 and 3 ways) and round-robin (4 ways)
// instances share one clock and reset; expected values are hand-computed constants.
module tb_mux_nway_reg;

    logic clk;
    logic reset_n;

    // External select, 4 ways
    logic [127:0] m0_in_data;
    logic [3:0]   m0_in_valid, m0_in_ready;
    logic [1:0]   m0_sel, m0_out_src;
    logic [31:0]  m0_out_data;
    logic         m0_out_valid, m0_out_ready;

    // Round-robin, 4 ways
    logic [127:0] rr_in_data;
    logic [3:0]   rr_in_valid, rr_in_ready;
    logic [1:0]   rr_sel, rr_out_src;
    logic [31:0]  rr_out_data;
    logic         rr_out_valid, rr_out_ready;

    // External select, 3 ways
    logic [95:0]  n3_in_data;
    logic [2:0]   n3_in_valid, n3_in_ready;
    logic [1:0]   n3_sel, n3_out_src;
    logic [31:0]  n3_out_data;
    logic         n3_out_valid, n3_out_ready;

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [31:0] d4 [4];

    mux_nway_reg #(.WIDTH(32), .WAYS(4), .MODE(0)) u_m0 (
        .clk(clk), .reset_n(reset_n),
        .in_data(m0_in_data), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
        .sel(m0_sel), .out_data(m0_out_data), .out_valid(m0_out_valid),
        .out_ready(m0_out_ready), .out_src(m0_out_src)
    );

    mux_nway_reg #(.WIDTH(32), .WAYS(4), .MODE(1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .in_data(rr_in_data), .in_valid(rr_in_valid), .in_ready(rr_in_ready),
        .sel(rr_sel), .out_data(rr_out_data), .out_valid(rr_out_valid),
        .out_ready(rr_out_ready), .out_src(rr_out_src)
    );

    mux_nway_reg #(.WIDTH(32), .WAYS(3), .MODE(0)) u_n3 (
        .clk(clk), .reset_n(reset_n),
        .in_data(n3_in_data), .in_valid(n3_in_valid), .in_ready(n3_in_ready),
        .sel(n3_sel), .out_data(n3_out_data), .out_valid(n3_out_valid),
        .out_ready(n3_out_ready), .out_src(n3_out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d4[0] = 32'hAAAA_0000;
        d4[1] = 32'hBBBB_0001;
        d4[2] = 32'hCCCC_0002;
        d4[3] = 32'hDDDD_0003;
        m0_in_data = {d4[3], d4[2], d4[1], d4[0]};
        rr_in_data = {d4[3], d4[2], d4[1], d4[0]};
        n3_in_data = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        rr_sel = 2'd3;

        // Reset with every channel valid and the consumer ready
        reset_n = 1'b0;
        m0_in_valid = 4'b1111; m0_sel = 2'd0; m0_out_ready = 1'b1;
        rr_in_valid = 4'b1111; rr_out_ready = 1'b1;
        n3_in_valid = 3'b111;  n3_sel = 2'd0; n3_out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_m0_valid", 64'(m0_out_valid), 64'd0);
            chk("rst_m0_data",  64'(m0_out_data), 64'd0);
            chk("rst_m0_src",   64'(m0_out_src), 64'd0);
            chk("rst_m0_ready", 64'(m0_in_ready), 64'd0);
            chk("rst_rr_valid", 64'(rr_out_valid), 64'd0);
            chk("rst_rr_data",  64'(rr_out_data), 64'd0);
            chk("rst_rr_ready", 64'(rr_in_ready), 64'd0);
            chk("rst_n3_ready", 64'(n3_in_ready), 64'd0);
        end

        // Release; only the round-robin instance has traffic
        reset_n = 1'b1;
        m0_in_valid = 4'b0000;
        n3_in_valid = 3'b000;
        #1;
        chk("rr_first_ready", 64'(rr_in_ready), 64'b0001);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_seq%0d_src", k), 64'(rr_out_src), 64'(k % 4));
            chk($sformatf("rr_seq%0d_data", k), 64'(rr_out_data), 64'(d4[k % 4]));
            chk($sformatf("rr_seq%0d_valid", k), 64'(rr_out_valid), 64'd1);
        end
        // Pointer now sits at 2; only channels 3 and 0 request
        rr_in_valid = 4'b1001;
        #1;
        chk("rr_skip_ready", 64'(rr_in_ready), 64'b1000);
        tick();
        chk("rr_skip_src3", 64'(rr_out_src), 64'd3);
        chk("rr_wrap_ready", 64'(rr_in_ready), 64'b0001);
        tick();
        chk("rr_wrap_src0", 64'(rr_out_src), 64'd0);
        rr_in_valid = 4'b0000;
        tick();
        chk("rr_drain_valid", 64'(rr_out_valid), 64'd0);
        chk("rr_drain_src_hold", 64'(rr_out_src), 64'd0);

        // External select of channel 2
        m0_sel = 2'd2; m0_in_valid = 4'b0100; m0_out_ready = 1'b1;
        #1;
        chk("m0_sel2_ready", 64'(m0_in_ready), 64'b0100);
        tick();
        chk("m0_sel2_data",  64'(m0_out_data), 64'hCCCC_0002);
        chk("m0_sel2_src",   64'(m0_out_src), 64'd2);
        chk("m0_sel2_valid", 64'(m0_out_valid), 64'd1);

        // Backpressure; sel moves mid-stall and must have no effect
        m0_out_ready = 1'b0; m0_in_valid = 4'b1111; m0_sel = 2'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("m0_stall%0d_ready", c), 64'(m0_in_ready), 64'd0);
            tick();
            chk($sformatf("m0_stall%0d_data", c), 64'(m0_out_data), 64'hCCCC_0002);
            chk($sformatf("m0_stall%0d_src", c), 64'(m0_out_src), 64'd2);
            chk($sformatf("m0_stall%0d_valid", c), 64'(m0_out_valid), 64'd1);
        end
        m0_out_ready = 1'b1;
        #1;
        chk("m0_resume_ready", 64'(m0_in_ready), 64'b0001);
        tick();
        chk("m0_swap_valid", 64'(m0_out_valid), 64'd1);
        chk("m0_swap_data",  64'(m0_out_data), 64'hAAAA_0000);
        chk("m0_swap_src",   64'(m0_out_src), 64'd0);

        // Hold a word in m0; load channel 1 into rr (pointer moves to 2)
        m0_out_ready = 1'b0; m0_in_valid = 4'b0000;
        rr_out_ready = 1'b0; rr_in_valid = 4'b0010;
        tick();
        chk("rr_held_src", 64'(rr_out_src), 64'd1);
        chk("m0_held_valid", 64'(m0_out_valid), 64'd1);

        // Reset mid-stall discards held words and the pointer
        reset_n = 1'b0; m0_in_valid = 4'b1111; rr_in_valid = 4'b1111;
        #1;
        chk("rst_mid_m0_ready", 64'(m0_in_ready), 64'd0);
        chk("rst_mid_rr_ready", 64'(rr_in_ready), 64'd0);
        tick();
        chk("rst_mid_m0_valid", 64'(m0_out_valid), 64'd0);
        chk("rst_mid_m0_data",  64'(m0_out_data), 64'd0);
        chk("rst_mid_m0_src",   64'(m0_out_src), 64'd0);
        chk("rst_mid_rr_valid", 64'(rr_out_valid), 64'd0);
        chk("rst_mid_rr_data",  64'(rr_out_data), 64'd0);
        reset_n = 1'b1; m0_in_valid = 4'b0000; rr_out_ready = 1'b1;
        #1;
        chk("rst_mid_rr_ptr0", 64'(rr_in_ready), 64'b0001);
        tick();
        chk("rst_mid_rr_src", 64'(rr_out_src), 64'd0);
        rr_in_valid = 4'b0000;

        // Three ways: out-of-range select loads nothing
        n3_sel = 2'd3; n3_in_valid = 3'b111; n3_out_ready = 1'b1;
        #1;
        chk("n3_sel3_ready", 64'(n3_in_ready), 64'd0);
        tick();
        chk("n3_sel3_valid_a", 64'(n3_out_valid), 64'd0);
        tick();
        chk("n3_sel3_valid_b", 64'(n3_out_valid), 64'd0);
        n3_sel = 2'd1;
        #1;
        chk("n3_sel1_ready", 64'(n3_in_ready), 64'b010);
        tick();
        chk("n3_sel1_valid", 64'(n3_out_valid), 64'd1);
        chk("n3_sel1_data",  64'(n3_out_data), 64'h2222_0001);
        chk("n3_sel1_src",   64'(n3_out_src), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
